// File: rtl/iluminacao_zonas_ctrl.sv
// Multi-zone lighting controller: per-zone presence/inactivity timers feeding a
// round-robin arbiter that issues on/off commands over one valid/ready relay port.
module iluminacao_zonas_ctrl #(
    parameter int N_ZONES         = 4,
    parameter int AUTO_SHUTDOWN_T = 30000,
    parameter int TW              = 16,
    localparam int ZW             = ($clog2(N_ZONES) > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [N_ZONES-1:0] infra,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [ZW-1:0]      cmd_zone,
    output logic               cmd_on,
    output logic [N_ZONES-1:0] lamp_on
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state_q, state_d;
    logic [N_ZONES-1:0]   lamp_q, lamp_d;
    logic [N_ZONES-1:0]   pend_on_q, pend_on_d;
    logic [N_ZONES-1:0]   pend_off_q, pend_off_d;
    logic [TW-1:0]        tc_q [N_ZONES];
    logic [TW-1:0]        tc_d [N_ZONES];
    logic [ZW-1:0]        cmd_zone_q, cmd_zone_d;
    logic                 cmd_on_q, cmd_on_d;
    logic [ZW-1:0]        rr_q, rr_d;

    logic                 hs;
    logic [N_ZONES-1:0]   pend;
    logic                 found;
    logic [ZW-1:0]        sel;
    int unsigned          idx;

    assign hs        = (state_q == ISSUE) && cmd_ready;
    assign pend      = pend_on_q | pend_off_q;
    assign cmd_valid = (state_q == ISSUE);
    assign cmd_zone  = cmd_zone_q;
    assign cmd_on    = cmd_on_q;
    assign lamp_on   = lamp_q;

    // Per-zone state; handshake effects are applied last so they win over a
    // same-cycle set of the flag they retire.
    always_comb begin
        lamp_d     = lamp_q;
        pend_on_d  = pend_on_q;
        pend_off_d = pend_off_q;
        for (int unsigned i = 0; i < N_ZONES; i++) begin
            tc_d[i] = tc_q[i];
            if (infra[i]) begin
                tc_d[i]       = '0;
                pend_off_d[i] = 1'b0;
                if (enable && !lamp_q[i]) begin
                    pend_on_d[i] = 1'b1;
                end
            end else if (!enable || !lamp_q[i]) begin
                tc_d[i] = '0;
            end else if (!pend_off_q[i]) begin
                if (tc_q[i] == TW'(AUTO_SHUTDOWN_T)) begin
                    pend_off_d[i] = 1'b1;
                    tc_d[i]       = '0;
                end else begin
                    tc_d[i] = tc_q[i] + 1'b1;
                end
            end
            if (hs && (cmd_zone_q == ZW'(i))) begin
                lamp_d[i] = cmd_on_q;
                if (cmd_on_q) begin
                    pend_on_d[i] = 1'b0;
                end else begin
                    pend_off_d[i] = 1'b0;
                end
            end
        end
    end

    // Round-robin search starting at rr_q.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N_ZONES; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= N_ZONES) begin
                idx = idx - N_ZONES;
            end
            if (!found && pend[ZW'(idx)]) begin
                found = 1'b1;
                sel   = ZW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_zone_d = cmd_zone_q;
        cmd_on_d   = cmd_on_q;
        rr_d       = rr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    cmd_zone_d = sel;
                    cmd_on_d   = pend_on_q[sel];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    rr_d    = (cmd_zone_q == ZW'(N_ZONES - 1)) ? '0 : cmd_zone_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lamp_q     <= '0;
            pend_on_q  <= '0;
            pend_off_q <= '0;
            cmd_zone_q <= '0;
            cmd_on_q   <= 1'b0;
            rr_q       <= '0;
            for (int unsigned i = 0; i < N_ZONES; i++) begin
                tc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lamp_q     <= lamp_d;
            pend_on_q  <= pend_on_d;
            pend_off_q <= pend_off_d;
            cmd_zone_q <= cmd_zone_d;
            cmd_on_q   <= cmd_on_d;
            rr_q       <= rr_d;
            for (int unsigned i = 0; i < N_ZONES; i++) begin
                tc_q[i] <= tc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_iluminacao_zonas_ctrl.sv
// Directed bench for iluminacao_zonas_ctrl: expected relay commands are queued
// when stimulus is applied and compared when the handshake happens.
module tb_iluminacao_zonas_ctrl;

    localparam int T = 10;

    typedef struct packed {
        logic [1:0] zone;
        logic       on;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] infra;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_zone;
    logic       cmd_on;
    logic [3:0] lamp_on;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned grants   = 0;
    int unsigned last_grant = 0;
    cmd_t        exp_q [$];
    cmd_t        popped;

    iluminacao_zonas_ctrl #(
        .N_ZONES(4),
        .AUTO_SHUTDOWN_T(T),
        .TW(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .infra(infra),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_zone(cmd_zone),
        .cmd_on(cmd_on),
        .lamp_on(lamp_on)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] zone, input logic on);
        cmd_t c;
        c.zone = zone;
        c.on   = on;
        exp_q.push_back(c);
    endtask

    task automatic drain(input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (!cmd_valid && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, cmd_valid, 1);
    endtask

    // Inputs only change just after a rising edge, so the level seen here is
    // what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_cmd", {cmd_zone, cmd_on}, 32'hFFFF);
            end else begin
                popped = exp_q.pop_front();
                chk("sb_zone", cmd_zone, popped.zone);
                chk("sb_on", cmd_on, popped.on);
            end
            grants++;
            if (grants > 1) chk("grant_spacing_ge2", (cyc - last_grant) >= 2, 1);
            last_grant = cyc;
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        enable    = 1'b1;
        infra     = '0;
        cmd_ready = 1'b1;
        tick(2);
        chk("rst_lamp", lamp_on, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_zone", cmd_zone, 0);
        chk("rst_on", cmd_on, 0);
        rst = 1'b1;
        tick(1);

        // ON for zone 2: pend at k, ISSUE at k+1, handshake at k+2
        infra = 4'b0100;
        push(2, 1);
        tick(1);
        infra = '0;
        chk("on2_valid_k", cmd_valid, 0);
        tick(1);
        chk("on2_valid_k1", cmd_valid, 1);
        chk("on2_zone", cmd_zone, 2);
        chk("on2_on", cmd_on, 1);
        chk("on2_lamp_before", lamp_on, 4'b0000);
        tick(1);
        chk("on2_lamp_after", lamp_on, 4'b0100);
        chk("on2_valid_after", cmd_valid, 0);

        // Shutdown from last presence at e0 on a lit zone
        infra = 4'b0100;
        tick(1);
        infra = '0;
        push(2, 0);
        tick(T + 1);
        chk("off2_valid_early", cmd_valid, 0);
        tick(1);
        chk("off2_valid", cmd_valid, 1);
        chk("off2_zone", cmd_zone, 2);
        chk("off2_on", cmd_on, 0);
        tick(1);
        chk("off2_lamp", lamp_on, 4'b0000);

        // Asynchronous reset in the middle of a stalled command
        infra = 4'b1000;
        push(3, 1);
        tick(1);
        infra = '0;
        drain(10, "drain_on3");
        chk("pre_rst_lamp", lamp_on, 4'b1000);
        cmd_ready = 1'b0;
        infra = 4'b0010;
        tick(1);
        infra = '0;
        tick(2);
        chk("pre_rst_valid", cmd_valid, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_lamp", lamp_on, 0);
        chk("async_rst_valid", cmd_valid, 0);
        chk("async_rst_zone", cmd_zone, 0);
        chk("async_rst_on", cmd_on, 0);
        tick(2);
        rst = 1'b1;
        cmd_ready = 1'b1;
        tick(2);
        chk("post_rst_lamp", lamp_on, 0);
        chk("post_rst_valid", cmd_valid, 0);

        // Round robin from rr_ptr=0, then the resulting shutdowns
        infra = 4'b1011;
        push(0, 1);
        push(1, 1);
        push(3, 1);
        tick(1);
        infra = '0;
        drain(20, "drain_rr_on");
        chk("rr_on_lamp", lamp_on, 4'b1011);
        push(0, 0);
        push(1, 0);
        push(3, 0);
        drain(40, "drain_rr_off");
        chk("rr_off_lamp", lamp_on, 4'b0000);

        infra = 4'b1001;
        push(0, 1);
        push(3, 1);
        tick(1);
        infra = '0;
        drain(20, "drain_rr_30");
        chk("rr_30_lamp", lamp_on, 4'b1001);

        // Stalled ON for zone 2: outputs hold for 20 cycles
        cmd_ready = 1'b0;
        infra = 4'b0100;
        push(2, 1);
        tick(1);
        infra = '0;
        tick(1);
        for (int n = 0; n < 20; n++) begin
            chk("stall_valid", cmd_valid, 1);
            chk("stall_zone", cmd_zone, 2);
            chk("stall_on", cmd_on, 1);
            chk("stall_lamp", lamp_on, 4'b1001);
            tick(1);
        end
        cmd_ready = 1'b1;
        tick(1);
        chk("stall_release_lamp", lamp_on, 4'b1101);
        push(3, 0);
        push(0, 0);
        push(2, 0);
        drain(40, "drain_stall_off");
        chk("stall_off_lamp", lamp_on, 4'b0000);

        // OFF for zone 1 stalled while presence returns
        infra = 4'b0010;
        push(1, 1);
        tick(1);
        infra = '0;
        drain(20, "drain_on1");
        cmd_ready = 1'b0;
        wait_valid(30, "off1_valid_timeout");
        chk("off1_zone", cmd_zone, 1);
        chk("off1_on", cmd_on, 0);
        infra = 4'b0010;
        tick(3);
        chk("off1_hold_valid", cmd_valid, 1);
        chk("off1_hold_on", cmd_on, 0);
        chk("off1_hold_lamp", lamp_on, 4'b0010);
        push(1, 0);
        push(1, 1);
        cmd_ready = 1'b1;
        drain(20, "drain_off_on1");
        chk("off_on1_lamp", lamp_on, 4'b0010);
        infra = '0;
        push(1, 0);
        drain(30, "drain_off1_final");
        chk("off1_final_lamp", lamp_on, 4'b0000);

        // enable=0 freezes shutdown and blocks new ON requests
        infra = 4'b0001;
        push(0, 1);
        tick(1);
        infra = '0;
        drain(20, "drain_on0");
        tick(3);
        enable = 1'b0;
        for (int n = 0; n < 3 * T; n++) begin
            infra = (n >= 5 && n < 7) ? 4'b0100 : 4'b0000;
            tick(1);
            chk("dis_valid", cmd_valid, 0);
        end
        infra = '0;
        chk("dis_lamp", lamp_on, 4'b0001);
        push(0, 0);
        enable = 1'b1;
        tick(1);
        tick(T - 1);
        tick(1);
        chk("reen_valid_early", cmd_valid, 0);
        tick(1);
        chk("reen_valid", cmd_valid, 1);
        chk("reen_zone", cmd_zone, 0);
        chk("reen_on", cmd_on, 0);
        drain(10, "drain_reen");
        chk("reen_lamp", lamp_on, 4'b0000);
        tick(5);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iluminacao_zonas_ctrl.md
# iluminacao_zonas_ctrl

Multi-zone lighting controller that owns the lamp relay command channel for `N_ZONES` lighting zones. Each zone has a presence sensor and an inactivity timer; the block turns a zone on when presence appears and off after `AUTO_SHUTDOWN_T` idle cycles. All on/off requests share one relay-driver command port, arbitrated round-robin with a valid/ready handshake. It sits between the per-zone infrared sensors and the relay driver.

## Interface
- `N_ZONES`, 4, number of zones (≥2).
- `AUTO_SHUTDOWN_T`, 30000, idle cycles before a lit zone requests shutdown.
- `TW`, 16, timer width; must satisfy `AUTO_SHUTDOWN_T < 2**TW`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  global enable; 0 freezes timers and blocks new turn-on requests.
- `infra`  in  N_ZONES  per-zone presence, 1 = presence detected (synchronous inputs).
- `cmd_valid`  out  1  relay command valid.
- `cmd_ready`  in  1  relay driver accepts the command.
- `cmd_zone`  out  ZW  zone index of the command, `ZW = max(1, $clog2(N_ZONES))`.
- `cmd_on`  out  1  1 = switch on, 0 = switch off.
- `lamp_on`  out  N_ZONES  committed lamp state per zone.

## Operation
- Per-zone registers: `lamp_on[i]`, `pend_on[i]`, `pend_off[i]`, timer `tc[i]` (TW bits).
- Presence (`infra[i]=1`): `tc[i]<=0`; `pend_off[i]<=0`; if `enable && !lamp_on[i]`, `pend_on[i]<=1`.
- Timer counts (`tc[i]<=tc[i]+1`) only when `enable && lamp_on[i] && !infra[i] && !pend_off[i]`. Otherwise it holds, except it is cleared by presence, by `enable=0`, and by `lamp_on[i]=0`.
- When counting and `tc[i]==AUTO_SHUTDOWN_T`: `pend_off[i]<=1`, `tc[i]<=0` (no increment). Counter never exceeds `AUTO_SHUTDOWN_T`.
- `pend_on[i]` and `pend_off[i]` are never both 1.
- Arbiter FSM, two states:
  - IDLE: `cmd_valid=0`. If any pending flag is set, it picks the first zone with a pending flag, searching `rr_ptr, rr_ptr+1, …` with wrap at `N_ZONES`. It latches `cmd_zone`, and latches `cmd_on` (1 if `pend_on`, 0 if `pend_off`), then goes to ISSUE.
  - ISSUE: `cmd_valid=1`, with `cmd_zone` and `cmd_on` held stable until the handshake.
    - On `cmd_valid && cmd_ready`: `lamp_on[cmd_zone]<=cmd_on`; clear the pending flag of the issued direction; `rr_ptr<=(cmd_zone+1) mod N_ZONES`; go to IDLE.
- Commands are never withdrawn. If presence arrives while an OFF command for that zone is in ISSUE:
  - `pend_off` clears immediately, but the command still completes and `lamp_on` goes to 0.
  - Then, if `infra` is still 1 and `enable=1`, `pend_on` is set on the next edge.
- `enable=0`: lit zones stay lit, and already pending flags are still serviced.
- Reset: all `lamp_on`, `pend_*`, `tc` = 0; FSM = IDLE; `cmd_valid=0`, `cmd_zone=0`, `cmd_on=0`, `rr_ptr=0`. Reset mid-handshake drops the command, and lamp state returns to 0.

## Timing
- Pending flag set at edge k → FSM enters ISSUE at edge k+1 → `cmd_valid` high in the cycle after edge k+1.
- Handshake at edge h → `lamp_on` update visible after h; FSM is in IDLE for ≥1 cycle, so `cmd_valid` is 0 for at least the cycle after h. Back-to-back grants are therefore spaced ≥2 cycles.
- Presence sampled at edge k → `pend_on` at k → `cmd_valid` after k+1 (latency 2 edges).
- Shutdown: presence is last sampled at edge e0 (`tc=0`). `tc` reaches `AUTO_SHUTDOWN_T` at edge e0+T, `pend_off` is set at e0+T+1, and `cmd_valid` rises after e0+T+2.
- `cmd_valid` may stay high indefinitely while `cmd_ready=0`; outputs stay stable during the wait.

## Test plan
- Reset with `rst=0` mid-operation → all outputs 0 immediately (async); after release, `lamp_on=0000`, `cmd_valid=0`.
- `AUTO_SHUTDOWN_T=10`, `cmd_ready=1`; pulse `infra[2]` for 1 cycle → ON command for zone 2 (`cmd_zone=2`, `cmd_on=1`) 2 edges later, `lamp_on[2]=1`. OFF command (`cmd_on=0`) `cmd_valid` rises after edge e0+12, then `lamp_on[2]=0`.
- Presence on zones 0, 1, 3 in the same cycle, with `cmd_ready=1` → grants in order 0, 1, 3, each ≥2 cycles apart. Then, with `rr_ptr=0`, simultaneous requests on zones 3 and 0 → zone 0 granted first.
- `cmd_ready=0` for 20 cycles during an ON command → `cmd_valid`, `cmd_zone`, `cmd_on` stable throughout; `lamp_on` changes only after `cmd_ready=1`.
- Zone 1 OFF command pending with `cmd_ready=0`, then `infra[1]=1` held → OFF completes when ready (`lamp_on[1]=0`), followed by a new ON command for zone 1.
- `enable=0` with zone 0 lit and idle for 3×T cycles → no OFF request, `tc` stays 0. Presence on unlit zone 2 → no ON request.
